// File: rtl/pc_pkg.sv
// Shared encodings and constants for the fetch PC sequencer.
package pc_pkg;

    localparam int unsigned PC_SRC_W   = 2;
    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [PC_SRC_W-1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JALR   = 2'b10,
        PC_SRC_JAL    = 2'b11
    } pc_src_e;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack: full pushes overwrite the oldest entry, empty pops are ignored.
module return_address_stack #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic            valid,
    output logic [XLEN-1:0] top
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] top_idx;

    // ptr is the next free slot; the top entry sits one below it.
    assign top_idx = ptr - PTR_W'(1);

    // Stack storage, write pointer and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                entries[i] <= '0;
            end
            ptr   <= '0;
            count <= '0;
        end else if (push && pop && (count != '0)) begin
            entries[top_idx] <= push_data;
        end else if (push) begin
            entries[ptr] <= push_data;
            ptr          <= ptr + PTR_W'(1);
            if (count != CNT_W'(RAS_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && (count != '0)) begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
        end
    end

    // Expose the top entry, or zero when empty.
    always_comb begin
        valid = (count != '0);
        top   = valid ? entries[top_idx] : '0;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: target selection, alignment check, trap/stall priority and RAS hint.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = 64,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic [PC_SRC_W-1:0] pc_src,
    input  logic                branch_taken,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     alu_result,
    input  logic                is_call,
    input  logic                is_return,
    input  logic                trap,
    input  logic [XLEN-1:0]     trap_vector,
    output logic [XLEN-1:0]     pc_current,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                misaligned,
    output logic [XLEN-1:0]     ras_top,
    output logic                ras_valid
);

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] rel_target;
    logic            redirect;
    logic            is_jump;
    logic            misalign_c;
    logic            advance;
    logic            ras_push;
    logic            ras_pop;

    assign pc_plus4 = pc_current + XLEN'(INSN_BYTES);

    // Target mux plus the qualifiers that gate the PC and RAS updates.
    always_comb begin
        target     = pc_plus4;
        redirect   = 1'b0;
        is_jump    = 1'b0;
        rel_target = pc_current + (imm << 1);
        case (pc_src_e'(pc_src))
            PC_SRC_BRANCH: begin
                if (branch_taken) begin
                    target   = rel_target;
                    redirect = 1'b1;
                end
            end
            PC_SRC_JALR: begin
                target   = alu_result & ~XLEN'(1);
                redirect = 1'b1;
                is_jump  = 1'b1;
            end
            PC_SRC_JAL: begin
                target   = rel_target;
                redirect = 1'b1;
                is_jump  = 1'b1;
            end
            default: begin
                target = pc_plus4;
            end
        endcase
        misalign_c = redirect && (target[1:0] != 2'b00);
        advance    = !trap && !stall && !misalign_c;
        ras_push   = advance && is_jump && is_call;
        ras_pop    = advance && is_jump && is_return;
    end

    // PC and misaligned flag with priority trap > stall > misaligned > normal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_current <= RESET_VECTOR;
            misaligned <= 1'b0;
        end else if (trap) begin
            pc_current <= trap_vector;
            misaligned <= 1'b0;
        end else if (stall) begin
            pc_current <= pc_current;
            misaligned <= misaligned;
        end else if (misalign_c) begin
            misaligned <= 1'b1;
        end else begin
            pc_current <= target;
            misaligned <= 1'b0;
        end
    end

    return_address_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .valid     (ras_valid),
        .top       (ras_top)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with XLEN=64, RESET_VECTOR=0x1000, RAS_DEPTH=4.
module tb_pc_sequencer;

    localparam int unsigned XLEN = 64;
    localparam logic [XLEN-1:0] RV = 64'h1000;

    logic            clock = 1'b0;
    logic            reset;
    logic            stall;
    logic [1:0]      pc_src;
    logic            branch_taken;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_result;
    logic            is_call;
    logic            is_return;
    logic            trap;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] pc_current;
    logic [XLEN-1:0] pc_plus4;
    logic            misaligned;
    logic [XLEN-1:0] ras_top;
    logic            ras_valid;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .imm          (imm),
        .alu_result   (alu_result),
        .is_call      (is_call),
        .is_return    (is_return),
        .trap         (trap),
        .trap_vector  (trap_vector),
        .pc_current   (pc_current),
        .pc_plus4     (pc_plus4),
        .misaligned   (misaligned),
        .ras_top      (ras_top),
        .ras_valid    (ras_valid)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; pc_src = 2'b00; branch_taken = 0; imm = '0; alu_result = '0;
        is_call = 0; is_return = 0; trap = 0; trap_vector = '0;
    endtask

    task automatic set_pc(input logic [XLEN-1:0] v);
        trap = 1; trap_vector = v;
        step();
        trap = 0; trap_vector = '0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        #2;
        checks++; if (pc_current !== RV) begin errors++; $display("FAIL reset_pc got=%h want=%h", pc_current, RV); end
        checks++; if (pc_plus4 !== 64'h1004) begin errors++; $display("FAIL reset_pc_plus4 got=%h want=%h", pc_plus4, 64'h1004); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%b want=0", misaligned); end
        checks++; if (ras_valid !== 1'b0 || ras_top !== '0) begin errors++; $display("FAIL reset_ras got=%b/%h want=0/0", ras_valid, ras_top); end
        step();
        reset = 0;
        checks++; if (pc_current !== RV) begin errors++; $display("FAIL release_pc got=%h want=%h", pc_current, RV); end
    endtask

    task automatic test_seq();
        logic [XLEN-1:0] exp_pc [3] = '{64'h1004, 64'h1008, 64'h100C};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc_current !== exp_pc[i]) begin errors++; $display("FAIL seq%0d got=%h want=%h", i, pc_current, exp_pc[i]); end
        end
    endtask

    task automatic test_branch();
        pc_src = 2'b01; imm = 64'h8; branch_taken = 1;
        step();
        checks++; if (pc_current !== 64'h101C) begin errors++; $display("FAIL branch_taken got=%h want=%h", pc_current, 64'h101C); end
        idle_inputs();
        set_pc(64'h100C);
        pc_src = 2'b01; imm = 64'h8; branch_taken = 0;
        step();
        checks++; if (pc_current !== 64'h1010) begin errors++; $display("FAIL branch_not_taken got=%h want=%h", pc_current, 64'h1010); end
        idle_inputs();
    endtask

    task automatic test_call_return();
        set_pc(64'h2000);
        pc_src = 2'b11; imm = 64'h80; is_call = 1;
        step();
        idle_inputs();
        checks++; if (pc_current !== 64'h2100) begin errors++; $display("FAIL jal_call_pc got=%h want=%h", pc_current, 64'h2100); end
        checks++; if (ras_valid !== 1'b1 || ras_top !== 64'h2004) begin errors++; $display("FAIL jal_call_ras got=%b/%h want=1/%h", ras_valid, ras_top, 64'h2004); end
        step();
        checks++; if (ras_top !== 64'h2004) begin errors++; $display("FAIL seq_keeps_ras got=%h want=%h", ras_top, 64'h2004); end
        pc_src = 2'b10; alu_result = 64'h2004; is_return = 1;
        step();
        idle_inputs();
        checks++; if (pc_current !== 64'h2004) begin errors++; $display("FAIL jalr_ret_pc got=%h want=%h", pc_current, 64'h2004); end
        checks++; if (ras_valid !== 1'b0 || ras_top !== '0) begin errors++; $display("FAIL jalr_ret_ras got=%b/%h want=0/0", ras_valid, ras_top); end
    endtask

    task automatic test_ras_overflow();
        logic [XLEN-1:0] exp_top [4] = '{64'h4304, 64'h4204, 64'h4104, 64'h0};
        set_pc(64'h4000);
        pc_src = 2'b11; imm = 64'h80; is_call = 1;
        for (int i = 0; i < 5; i++) step();
        idle_inputs();
        checks++; if (pc_current !== 64'h4500) begin errors++; $display("FAIL five_calls_pc got=%h want=%h", pc_current, 64'h4500); end
        checks++; if (ras_top !== 64'h4404) begin errors++; $display("FAIL five_calls_top got=%h want=%h", ras_top, 64'h4404); end
        pc_src = 2'b10; alu_result = 64'h5000; is_return = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (ras_top !== exp_top[i] || ras_valid !== (i < 3)) begin errors++; $display("FAIL pop%0d got=%b/%h want=%b/%h", i, ras_valid, ras_top, i < 3, exp_top[i]); end
        end
        step();
        checks++; if (ras_valid !== 1'b0 || ras_top !== '0 || pc_current !== 64'h5000) begin errors++; $display("FAIL empty_pop got=%b/%h pc=%h want=0/0 pc=5000", ras_valid, ras_top, pc_current); end
        idle_inputs();
        // Call then simultaneous call+return: top replaced, depth unchanged.
        set_pc(64'h6000);
        pc_src = 2'b11; imm = 64'h80; is_call = 1;
        step();
        pc_src = 2'b10; alu_result = 64'h7000; is_call = 1; is_return = 1;
        step();
        idle_inputs();
        checks++; if (pc_current !== 64'h7000 || ras_top !== 64'h6104 || ras_valid !== 1'b1) begin errors++; $display("FAIL push_pop got=%h/%h/%b want=7000/6104/1", pc_current, ras_top, ras_valid); end
        // call/return flags ignored on branch
        pc_src = 2'b01; branch_taken = 1; imm = 64'h4; is_call = 1; is_return = 1;
        step();
        idle_inputs();
        checks++; if (pc_current !== 64'h7008 || ras_top !== 64'h6104) begin errors++; $display("FAIL branch_ignores_ras got=%h/%h want=7008/6104", pc_current, ras_top); end
    endtask

    task automatic test_misaligned_trap();
        set_pc(64'h3000);
        pc_src = 2'b10; alu_result = 64'h3002; is_call = 1;
        step();
        idle_inputs();
        checks++; if (pc_current !== 64'h3000 || misaligned !== 1'b1) begin errors++; $display("FAIL misaligned_hit got=%h/%b want=3000/1", pc_current, misaligned); end
        checks++; if (ras_top !== 64'h6104) begin errors++; $display("FAIL misaligned_ras got=%h want=6104", ras_top); end
        step();
        checks++; if (pc_current !== 64'h3004 || misaligned !== 1'b0) begin errors++; $display("FAIL misaligned_clear got=%h/%b want=3004/0", pc_current, misaligned); end
        pc_src = 2'b10; alu_result = 64'h3009;
        step();
        idle_inputs();
        checks++; if (pc_current !== 64'h3008 || misaligned !== 1'b0) begin errors++; $display("FAIL jalr_bit0 got=%h/%b want=3008/0", pc_current, misaligned); end
        pc_src = 2'b11; imm = 64'h1;
        step();
        idle_inputs();
        checks++; if (pc_current !== 64'h3008 || misaligned !== 1'b1) begin errors++; $display("FAIL jal_misaligned got=%h/%b want=3008/1", pc_current, misaligned); end
        stall = 1;
        step();
        checks++; if (pc_current !== 64'h3008 || misaligned !== 1'b1) begin errors++; $display("FAIL stall_hold got=%h/%b want=3008/1", pc_current, misaligned); end
        trap = 1; trap_vector = 64'h8000;
        step();
        idle_inputs();
        checks++; if (pc_current !== 64'h8000 || misaligned !== 1'b0) begin errors++; $display("FAIL trap_in_stall got=%h/%b want=8000/0", pc_current, misaligned); end
    endtask

    task automatic test_wrap_and_reset();
        set_pc(64'hFFFF_FFFF_FFFF_FFFC);
        checks++; if (pc_plus4 !== '0) begin errors++; $display("FAIL wrap_plus4 got=%h want=0", pc_plus4); end
        step();
        checks++; if (pc_current !== '0) begin errors++; $display("FAIL wrap_pc got=%h want=0", pc_current); end
        stall = 1;
        step();
        #2 reset = 1;
        #1;
        checks++; if (pc_current !== RV || ras_valid !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL async_reset got=%h/%b/%b want=1000/0/0", pc_current, ras_valid, misaligned); end
        idle_inputs();
        step();
        reset = 0;
        step();
        checks++; if (pc_current !== 64'h1004) begin errors++; $display("FAIL post_reset_seq got=%h want=1004", pc_current); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_call_return();
        test_ras_overflow();
        test_misaligned_trap();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
